// File: rtl/apb4_mem_slave_if.sv
// APB4 bus bundle between a master and the memory slave.
// Clock and reset are not carried here; they stay plain module ports.
interface apb4_mem_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                      PSELx;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [ADDR_WIDTH-1:0]     PADDR;
  logic [DATA_WIDTH-1:0]     PWDATA;
  logic [DATA_WIDTH/8-1:0]   PSTRB;
  logic [DATA_WIDTH-1:0]     PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb4_mem_slave.sv
// APB4 word-addressed memory slave with programmable wait states,
// an optional read-only upper region and a saturating error counter.
module apb4_mem_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0,
  parameter int RO_BASE     = DEPTH
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  apb4_mem_slave_if.slave        apb,
  output logic [7:0]             o_err_count
);

  localparam int NUM_LANES  = DATA_WIDTH / 8;
  localparam int ALIGN_BITS = $clog2(NUM_LANES);
  localparam int IDX_BITS   = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << ALIGN_BITS) - 1);
  localparam logic [3:0]            WAIT_LOAD  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic [7:0]              err_cnt_q, err_cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [DEPTH];

  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [IDX_BITS-1:0]     mem_idx;
  logic                    access_err;
  logic                    is_setup;

  // Address decode is only consumed on the access edge, so it may follow PADDR freely.
  always_comb begin
    word_idx   = apb.PADDR >> ALIGN_BITS;
    mem_idx    = word_idx[IDX_BITS-1:0];
    access_err = (word_idx >= ADDR_WIDTH'(DEPTH))
              || ((apb.PADDR & ALIGN_MASK) != '0)
              || (apb.PWRITE && (word_idx >= ADDR_WIDTH'(RO_BASE)));
    is_setup   = apb.PSELx && !apb.PENABLE;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    err_cnt_d = err_cnt_q;
    mem_d     = mem_q;

    case (state_q)
      IDLE: begin
        if (is_setup) begin
          state_d = WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end

      WAIT: begin
        if (!apb.PSELx) begin
          state_d = IDLE;
        end else if (apb.PENABLE) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d   = DONE;
            pready_d  = 1'b1;
            pslverr_d = access_err;
            if (access_err) begin
              if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
              if (!apb.PWRITE) prdata_d = '0;
            end else if (apb.PWRITE) begin
              for (int i = 0; i < NUM_LANES; i++) begin
                if (apb.PSTRB[i]) mem_d[mem_idx][8*i +: 8] = apb.PWDATA[8*i +: 8];
              end
            end else begin
              prdata_d = mem_q[mem_idx];
            end
          end
        end
      end

      DONE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        if (is_setup) begin
          state_d = WAIT;
          cnt_d   = WAIT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      err_cnt_q <= 8'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      err_cnt_q <= err_cnt_d;
      mem_q     <= mem_d;
    end
  end

  assign apb.PRDATA  = prdata_q;
  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;
  assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Scoreboard bench for apb4_mem_slave: directed APB cases plus random
// transfers checked against a word-array reference model.
module tb_apb4_mem_slave;

  localparam int DW          = 32;
  localparam int AW          = 32;
  localparam int DEPTH       = 16;
  localparam int WAIT_STATES = 2;
  localparam int RO_BASE     = 12;

  typedef struct {
    bit          wr;
    logic [31:0] rdata;
    bit          err;
    logic [7:0]  cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [7:0] err_count;

  apb4_mem_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  apb4_mem_slave #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .WAIT_STATES(WAIT_STATES),
    .RO_BASE    (RO_BASE)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .apb        (bus),
    .o_err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  exp_t        sbq[$];
  logic [31:0] refMem [DEPTH];
  logic [31:0] lastRdata;
  int          refErrCount;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
    lastRdata   = '0;
    refErrCount = 0;
  endtask

  task automatic idleBus(input int n);
    bus.PSELx   = 1'b0;
    bus.PENABLE = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // One full transfer; called at posedge+1, returns at posedge+1 after the PREADY edge.
  task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb);
    int   idx;
    bit   err;
    int   cycles;
    bit   seen;
    exp_t e;
    idx = int'(addr >> 2);
    err = (idx >= DEPTH) || (addr[1:0] != 2'b00) || (wr && idx >= RO_BASE);
    if (!err && wr) begin
      for (int i = 0; i < 4; i++) if (strb[i]) refMem[idx][8*i +: 8] = wdata[8*i +: 8];
    end
    if (!wr) lastRdata = err ? 32'h0 : refMem[idx];
    if (err && refErrCount < 255) refErrCount++;
    e.wr = wr; e.rdata = lastRdata; e.err = err; e.cnt = 8'(refErrCount);
    sbq.push_back(e);

    bus.PSELx   = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = ~wr;
    bus.PADDR   = $urandom;
    bus.PWDATA  = $urandom;
    bus.PSTRB   = 4'($urandom);
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    bus.PWRITE  = wr;
    bus.PADDR   = addr;
    bus.PWDATA  = wdata;
    bus.PSTRB   = strb;
    cycles = 1;
    seen   = 1'b0;
    while (!seen && cycles <= 20) begin
      @(negedge clk);
      if (bus.PREADY) seen = 1'b1;
      @(posedge clk); #1;
      if (!seen) cycles++;
    end
    checkOutput("access_cycles", seen ? 32'(cycles) : 32'hFFFF_FFFF, 32'(WAIT_STATES + 2));
  endtask

  task automatic abortTransfer(input logic [31:0] addr, input logic [31:0] wdata);
    bus.PSELx   = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = addr;
    bus.PWDATA  = wdata;
    bus.PSTRB   = 4'hF;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(negedge clk);
    checkOutput("abort_pready", 32'(bus.PREADY), 32'h0);
    @(posedge clk); #1;
    bus.PSELx   = 1'b0;
    bus.PENABLE = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkOutput("abort_pready_after", 32'(bus.PREADY), 32'h0);
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && bus.PREADY === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_pready: got PREADY=1, expected no completion at %0t", $time);
      end else begin
        e = sbq.pop_front();
        checkOutput(e.wr ? "write_prdata" : "read_prdata", bus.PRDATA, e.rdata);
        checkOutput("pslverr", 32'(bus.PSLVERR), 32'(e.err));
        checkOutput("err_count", 32'(err_count), 32'(e.cnt));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 500000");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    logic [31:0] addr;
    int          r;
    rst_n       = 1'b0;
    bus.PSELx   = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = '0;
    bus.PWDATA  = '0;
    bus.PSTRB   = '0;
    resetModel();
    #12;
    checkOutput("reset_pready", 32'(bus.PREADY), 32'h0);
    checkOutput("reset_pslverr", 32'(bus.PSLVERR), 32'h0);
    checkOutput("reset_prdata", bus.PRDATA, 32'h0);
    checkOutput("reset_err_count", 32'(err_count), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idleBus(2);

    applyStimulus(1'b1, 32'h08, 32'hDEADBEEF, 4'hF);
    idleBus(1);
    applyStimulus(1'b0, 32'h08, 32'h0, 4'h0);
    idleBus(1);
    applyStimulus(1'b1, 32'h08, 32'h11223344, 4'b0101);
    idleBus(1);
    applyStimulus(1'b0, 32'h08, 32'h0, 4'h0);
    idleBus(1);
    checkOutput("strobe_merge_model", refMem[2], 32'hDE22BE44);

    applyStimulus(1'b0, 32'h40, 32'h0, 4'h0);
    idleBus(1);
    applyStimulus(1'b0, 32'h09, 32'h0, 4'h0);
    idleBus(1);
    applyStimulus(1'b1, 32'h30, 32'hA5A5A5A5, 4'hF);
    idleBus(1);
    applyStimulus(1'b0, 32'h30, 32'h0, 4'h0);
    idleBus(1);

    applyStimulus(1'b1, 32'h0C, 32'h12345678, 4'hF);
    applyStimulus(1'b0, 32'h0C, 32'h0, 4'h0);
    idleBus(1);

    abortTransfer(32'h14, 32'hFEEDFACE);
    applyStimulus(1'b0, 32'h14, 32'h0, 4'h0);
    idleBus(1);

    // PENABLE without a preceding setup must not start a transfer.
    bus.PSELx   = 1'b1;
    bus.PENABLE = 1'b1;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = 32'h18;
    bus.PWDATA  = 32'h55AA55AA;
    bus.PSTRB   = 4'hF;
    repeat (3) begin
      @(negedge clk);
      checkOutput("penable_idle_pready", 32'(bus.PREADY), 32'h0);
      @(posedge clk); #1;
    end
    idleBus(2);
    applyStimulus(1'b0, 32'h18, 32'h0, 4'h0);
    idleBus(1);

    bus.PSELx   = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = 32'h10;
    bus.PWDATA  = 32'hCAFEF00D;
    bus.PSTRB   = 4'hF;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_pready", 32'(bus.PREADY), 32'h0);
    checkOutput("midreset_pslverr", 32'(bus.PSLVERR), 32'h0);
    checkOutput("midreset_prdata", bus.PRDATA, 32'h0);
    checkOutput("midreset_err_count", 32'(err_count), 32'h0);
    resetModel();
    bus.PSELx   = 1'b0;
    bus.PENABLE = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idleBus(2);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0);
    idleBus(1);
    applyStimulus(1'b1, 32'h10, 32'h0BADC0DE, 4'hF);
    idleBus(1);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0);
    idleBus(1);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (r == 7) addr = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      else             addr = 32'($urandom_range(DEPTH, 2 * DEPTH - 1)) << 2;
      applyStimulus(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom));
      if ($urandom_range(0, 1) == 1) idleBus($urandom_range(1, 2));
    end
    idleBus(3);

    checkOutput("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb4_mem_slave.md
APB4_MEM_SLAVE -- requirements
Module: apb4_mem_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning bus data width; legal values are 8, 16 and 32.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning PADDR width.
REQ-003 SHALL have parameter DEPTH, default 16, meaning number of DATA_WIDTH words; must be a power of two, 2..256.
REQ-004 SHALL have parameter WAIT_STATES, default 0, meaning extra access-phase cycles before PREADY; range 0..15.
REQ-005 SHALL have parameter RO_BASE, default DEPTH, meaning the first read-only word index; RO_BASE = DEPTH means no read-only region.
REQ-006 SHALL have port i_clk, input, 1 bit: APB clock; all logic is on the rising edge.
REQ-007 SHALL have port i_reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have ports PSELx (input, 1), PENABLE (input, 1), PWRITE (input, 1): APB select, enable and direction (1 = write).
REQ-009 SHALL have port PADDR, input, ADDR_WIDTH bits: byte address.
REQ-010 SHALL have port PWDATA, input, DATA_WIDTH bits: write data.
REQ-011 SHALL have port PSTRB, input, DATA_WIDTH/8 bits: write byte strobes; ignored on reads.
REQ-012 SHALL have port PRDATA, output, DATA_WIDTH bits: registered read data.
REQ-013 SHALL have ports PREADY (output, 1) and PSLVERR (output, 1): registered transfer-done and error flags.
REQ-014 SHALL have port o_err_count, output, 8 bits: saturating count of completed transfers that had PSLVERR set.

Function
REQ-015 SHALL compute word index = PADDR >> log2(DATA_WIDTH/8); alignment bits = PADDR[log2(DATA_WIDTH/8)-1:0].
REQ-016 SHALL implement the FSM states IDLE, WAIT and DONE.
REQ-017 IDLE: at an edge with PSELx=1 and PENABLE=0 (setup), SHALL load the wait counter with WAIT_STATES and go to WAIT.
REQ-018 WAIT, at an edge with PSELx=1 and PENABLE=1:
- if the counter is nonzero, SHALL decrement it;
- if the counter is 0, SHALL perform the access, set PREADY=1 and go to DONE.
REQ-019 WAIT with PSELx=0 (aborted transfer) SHALL return to IDLE with no memory write and PREADY held 0.
REQ-020 Access phase length SHALL be exactly WAIT_STATES+2 cycles, with PREADY high only in the last cycle.
REQ-021 DONE: at the next edge SHALL clear PREADY and PSLVERR. If that edge is a setup (back-to-back transfer), it SHALL go directly to WAIT; otherwise to IDLE.
REQ-022 Error condition SHALL be any of: index >= DEPTH; nonzero alignment bits; write with index >= RO_BASE.
REQ-023 On an error-free write, SHALL update each byte lane i where PSTRB[i]=1 and leave the other lanes unchanged.
REQ-024 On an error-free read, SHALL load PRDATA with the addressed word in the same edge that sets PREADY.
REQ-025 On error, SHALL set PSLVERR=1 with PREADY, SHALL NOT modify memory, and SHALL load PRDATA=0 on reads.
REQ-026 On writes, PRDATA SHALL hold its previous value.
REQ-027 o_err_count SHALL increment at each edge that sets PSLVERR=1 and saturate at 255.
REQ-028 PADDR, PWRITE, PWDATA and PSTRB SHALL be sampled only at the access edge; changes in earlier cycles have no effect.
REQ-029 PENABLE=1 while in IDLE SHALL be ignored: no state change and no access.

Reset
REQ-030 While i_reset_n=0, SHALL force, independent of i_clk: state=IDLE, PREADY=0, PSLVERR=0, PRDATA=0, o_err_count=0, wait counter=0, all memory words=0.
REQ-031 Reset mid-transfer SHALL abort it with no memory write; the first setup after reset release SHALL be handled normally.

Verification
REQ-032 Bench SHALL use DATA_WIDTH=32, DEPTH=16, WAIT_STATES=2, RO_BASE=12 and cover:
- Write 0xDEADBEEF to 0x08 with PSTRB=4'hF, then read 0x08 -> PRDATA=0xDEADBEEF, PSLVERR=0, PREADY high in the 4th access cycle of each transfer.
- Write 0x11223344 to 0x08 with PSTRB=4'b0101, then read -> PRDATA=0xDE22BE44.
- Read 0x40 (index 16) -> PSLVERR=1, PRDATA=0, o_err_count=1; read 0x09 (misaligned) -> PSLVERR=1, o_err_count=2.
- Write to 0x30 (index 12, read-only) -> PSLVERR=1, memory[12] stays 0.
- Back-to-back write then read with no IDLE cycle -> both complete with correct data; drop PSELx in the 2nd access cycle -> no write, PREADY never asserted.
- Assert i_reset_n=0 during WAIT of a write -> all outputs 0 immediately, target word unchanged (0), and the next transfer completes normally.
